// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache with one-word lines.
// It sits between the CPU fetch port and the SDRAM controller instruction port.
// Both sides use a level enable and a one-cycle valid pulse.
// Optional build macro ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_direct #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic              cpu_enable,
  output logic              cpu_valid,
  output logic [31:0]       cpu_result,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  input  logic              mem_valid,
  input  logic [31:0]       mem_result
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RESP
  } stateT;

  stateT stateQ, stateD;
  logic              cpuValidQ, cpuValidD;
  logic [31:0]       cpuResultQ, cpuResultD;
  logic              memEnableQ, memEnableD;
  logic [ADDR_W-1:0] memAddrQ, memAddrD;
  logic              flushPendingQ, flushPendingD;
  logic [LINES-1:0]  validQ, validD;

  logic [TAG_W-1:0]  tagQ  [LINES];
  logic [31:0]       dataQ [LINES];

  logic [IDX_W-1:0]  lookupIdx;
  logic [TAG_W-1:0]  lookupTag;
  logic              lookupHit;
  logic [IDX_W-1:0]  fillIdx;
  logic [TAG_W-1:0]  fillTag;
  logic              fillWrite;
  logic              hitEvent;
  logic              missEvent;

  // The offset bits and anything above the SDRAM address range never take part in a lookup.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{cpu_addr[31:ADDR_W], cpu_addr[1:0]};

  // Split the fetch address; the fill line comes from the address latched at miss time.
  always_comb begin
    lookupIdx = cpu_addr[IDX_W+1:2];
    lookupTag = cpu_addr[ADDR_W-1:IDX_W+2];
    fillIdx   = memAddrQ[IDX_W+1:2];
    fillTag   = memAddrQ[ADDR_W-1:IDX_W+2];
    // A flush in the same cycle as a request forces a miss.
    lookupHit = validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag) && !flush;
  end

  // Next-state and output logic for the lookup / fill / response sequence.
  always_comb begin
    stateD        = stateQ;
    cpuValidD     = cpuValidQ;
    cpuResultD    = cpuResultQ;
    memEnableD    = memEnableQ;
    memAddrD      = memAddrQ;
    flushPendingD = flushPendingQ;
    validD        = validQ;
    fillWrite     = 1'b0;
    hitEvent      = 1'b0;
    missEvent     = 1'b0;

    if (flush) begin
      validD = '0;
    end

    case (stateQ)
      IDLE: begin
        if (cpu_enable) begin
          if (lookupHit) begin
            cpuResultD = dataQ[lookupIdx];
            cpuValidD  = 1'b1;
            stateD     = RESP;
            hitEvent   = 1'b1;
          end else begin
            memAddrD   = {cpu_addr[ADDR_W-1:2], 2'b00};
            memEnableD = 1'b1;
            stateD     = FILL;
            missEvent  = 1'b1;
          end
        end
      end
      FILL: begin
        if (flush) begin
          flushPendingD = 1'b1;
        end
        if (mem_valid) begin
          memEnableD    = 1'b0;
          cpuResultD    = mem_result;
          cpuValidD     = 1'b1;
          stateD        = RESP;
          flushPendingD = 1'b0;
          // Data fetched across a flush is handed to the CPU but never installed.
          if (!(flushPendingQ || flush)) begin
            fillWrite        = 1'b1;
            validD[fillIdx]  = 1'b1;
          end
        end
      end
      RESP: begin
        cpuValidD = 1'b0;
        stateD    = IDLE;
      end
      default: begin
        stateD        = IDLE;
        cpuValidD     = 1'b0;
        memEnableD    = 1'b0;
        flushPendingD = 1'b0;
      end
    endcase
  end

  // State and control registers with synchronous reset; reset abandons any fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ        <= IDLE;
      cpuValidQ     <= 1'b0;
      cpuResultQ    <= NOP;
      memEnableQ    <= 1'b0;
      memAddrQ      <= '0;
      flushPendingQ <= 1'b0;
      validQ        <= '0;
    end else begin
      stateQ        <= stateD;
      cpuValidQ     <= cpuValidD;
      cpuResultQ    <= cpuResultD;
      memEnableQ    <= memEnableD;
      memAddrQ      <= memAddrD;
      flushPendingQ <= flushPendingD;
      validQ        <= validD;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (fillWrite) begin
      tagQ[fillIdx]  <= fillTag;
      dataQ[fillIdx] <= mem_result;
    end
  end

  assign cpu_valid  = cpuValidQ;
  assign cpu_result = cpuResultQ;
  assign mem_enable = memEnableQ;
  assign mem_addr   = memAddrQ;

`ifdef ICACHE_STATS_EN
  logic [31:0] statHitsQ, statMissesQ;

  // Saturating hit/miss counters; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      statHitsQ   <= '0;
      statMissesQ <= '0;
    end else begin
      if (hitEvent && (statHitsQ != 32'hFFFFFFFF)) begin
        statHitsQ <= statHitsQ + 32'd1;
      end
      if (missEvent && (statMissesQ != 32'hFFFFFFFF)) begin
        statMissesQ <= statMissesQ + 32'd1;
      end
    end
  end

  assign stat_hits   = statHitsQ;
  assign stat_misses = statMissesQ;
`else
  logic unusedEvents;
  assign unusedEvents = hitEvent ^ missEvent;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed and randomized fetch sequences for icache_direct,
// checked against an array-based reference of the cache contents.
module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_enable;
  logic        cpu_valid;
  logic [31:0] cpu_result;
  logic        flush;
  logic [24:0] mem_addr;
  logic        mem_enable;
  logic        mem_valid;
  logic [31:0] mem_result;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  icache_direct #(.LINES(16), .ADDR_W(25)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_enable (cpu_enable),
    .cpu_valid  (cpu_valid),
    .cpu_result (cpu_result),
    .flush      (flush),
    .mem_addr   (mem_addr),
    .mem_enable (mem_enable),
    .mem_valid  (mem_valid),
    .mem_result (mem_result)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference cache contents: what should be resident after each transaction.
  bit          modelValid [16];
  int unsigned modelTag   [16];
  logic [31:0] modelData  [16];
  int unsigned modelHits   = 0;
  int unsigned modelMisses = 0;

  // Reference memory image: fixed words from the test plan, otherwise a hash of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    int unsigned w;
    w = (addr & 32'h01FFFFFF) >> 2;
    case (w)
      0:       return 32'hDEADBEEF;
      2:       return 32'h22222222;
      16:      return 32'h11111111;
      default: return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endcase
  endfunction

  // Drop every resident line from the reference.
  task automatic modelFlush();
    for (int i = 0; i < 16; i++) modelValid[i] = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete CPU fetch: request, optional fill of 'lat' cycles, response, return to idle.
  task automatic applyStimulus(input logic [31:0] addr, input int lat,
                               input bit flushFill, input bit flushAccept);
    int unsigned idx, tag;
    bit          hit;
    logic [31:0] expData;
    logic [24:0] expAddr;

    idx     = (addr >> 2) % 16;
    tag     = (addr & 32'h01FFFFFF) >> 6;
    expAddr = addr[24:0] & ~25'h3;

    @(negedge clk);
    cpu_addr   = addr;
    cpu_enable = 1'b1;
    flush      = flushAccept;
    if (flushAccept) modelFlush();
    hit = modelValid[idx] && (modelTag[idx] == tag);
    @(posedge clk);
    #1;
    flush = 1'b0;

    if (hit) begin
      modelHits++;
      checkOutput("hit_valid", {31'b0, cpu_valid}, 32'd1);
      checkOutput("hit_data", cpu_result, modelData[idx]);
      checkOutput("hit_no_mem", {31'b0, mem_enable}, 32'd0);
    end else begin
      modelMisses++;
      expData = memWord(addr);
      checkOutput("miss_mem_en", {31'b0, mem_enable}, 32'd1);
      checkOutput("miss_mem_addr", {7'b0, mem_addr}, {7'b0, expAddr});
      checkOutput("miss_no_valid", {31'b0, cpu_valid}, 32'd0);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        cpu_addr   = $urandom;
        cpu_enable = 1'($urandom_range(0, 1));
        flush      = flushFill && (i == 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("fill_mem_en", {31'b0, mem_enable}, 32'd1);
        checkOutput("fill_mem_addr", {7'b0, mem_addr}, {7'b0, expAddr});
      end
      if (flushFill) modelFlush();
      @(negedge clk);
      mem_valid  = 1'b1;
      mem_result = expData;
      @(posedge clk);
      #1;
      mem_valid  = 1'b0;
      mem_result = $urandom;
      checkOutput("fill_valid", {31'b0, cpu_valid}, 32'd1);
      checkOutput("fill_data", cpu_result, expData);
      checkOutput("fill_mem_drop", {31'b0, mem_enable}, 32'd0);
      if (!flushFill) begin
        modelValid[idx] = 1'b1;
        modelTag[idx]   = tag;
        modelData[idx]  = expData;
      end
    end

    // The CPU's enable drop lags valid by one cycle; it must be ignored in the response cycle.
    @(negedge clk);
    cpu_enable = 1'($urandom_range(0, 1));
    cpu_addr   = $urandom;
    @(posedge clk);
    #1;
    cpu_enable = 1'b0;
    checkOutput("resp_valid_drop", {31'b0, cpu_valid}, 32'd0);
    checkOutput("resp_no_mem", {31'b0, mem_enable}, 32'd0);
  endtask

  initial begin
    logic [31:0] raddr;
    rst        = 1'b1;
    cpu_addr   = '0;
    cpu_enable = 1'b0;
    flush      = 1'b0;
    mem_valid  = 1'b0;
    mem_result = '0;
    modelFlush();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] checking reset state");
    checkOutput("rst_valid", {31'b0, cpu_valid}, 32'd0);
    checkOutput("rst_result", cpu_result, 32'h00000013);
    checkOutput("rst_mem_en", {31'b0, mem_enable}, 32'd0);
    checkOutput("rst_mem_addr", {7'b0, mem_addr}, 32'd0);

    $display("[TB] directed fetches");
    applyStimulus(32'h00000000, 5, 1'b0, 1'b0);
    applyStimulus(32'h00000000, 5, 1'b0, 1'b0);
    applyStimulus(32'h00000040, 3, 1'b0, 1'b0);
    applyStimulus(32'h00000000, 2, 1'b0, 1'b0);
    applyStimulus(32'h00000008, 3, 1'b1, 1'b0);
    applyStimulus(32'h00000008, 2, 1'b0, 1'b0);
    applyStimulus(32'h00000008, 2, 1'b0, 1'b0);
    applyStimulus(32'h00000008, 2, 1'b0, 1'b1);
    applyStimulus(32'hFE000008, 1, 1'b0, 1'b0);

    $display("[TB] reset during fill");
    @(negedge clk);
    cpu_addr   = 32'h0000000C;
    cpu_enable = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstfill_mem_en", {31'b0, mem_enable}, 32'd1);
    @(negedge clk);
    rst        = 1'b1;
    cpu_enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelFlush();
    @(negedge clk);
    mem_valid  = 1'b1;
    mem_result = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    checkOutput("rstfill_no_valid", {31'b0, cpu_valid}, 32'd0);
    checkOutput("rstfill_mem_en0", {31'b0, mem_enable}, 32'd0);
    checkOutput("rstfill_mem_addr", {7'b0, mem_addr}, 32'd0);
    checkOutput("rstfill_result", cpu_result, 32'h00000013);
    modelHits   = 0;
    modelMisses = 0;
    applyStimulus(32'h00000000, 2, 1'b0, 1'b0);

    $display("[TB] randomized fetches");
    for (int n = 0; n < 60; n++) begin
      raddr = {$urandom_range(0, 127), 25'h0} | ($urandom_range(0, 2) << 6)
            | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      applyStimulus(raddr, $urandom_range(1, 4),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

`ifdef ICACHE_STATS_EN
    $display("[TB] statistics counters");
    checkOutput("stat_hits", stat_hits, modelHits);
    checkOutput("stat_misses", stat_misses, modelMisses);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelFlush();
    applyStimulus(32'h00000000, 2, 1'b0, 1'b0);
    repeat (3) applyStimulus(32'h00000000, 2, 1'b0, 1'b0);
    applyStimulus(32'h00000004, 2, 1'b0, 1'b0);
    checkOutput("stat_hits_plan", stat_hits, 32'd3);
    checkOutput("stat_misses_plan", stat_misses, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
